// File: rtl/impix_avs_pixelizer_if.sv
// Avalon-MM bus between the HPS lightweight bridge (master) and the
// pixelizer register block (slave).
//
// Handshake: a command is accepted on a rising edge where avs_read or
// avs_write is high and avs_waitrequest is low. While avs_waitrequest is
// high the master holds address, strobes and writedata unchanged. A read
// accepted in cycle t returns avs_readdata together with a one-cycle
// avs_readdatavalid pulse in cycle t+1. avs_readdata means nothing
// outside that pulse.
interface impix_avs_pixelizer_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid, avs_waitrequest
    );
endinterface

// File: rtl/impix_avs_pixelizer.sv
// Tile pixelizer: accumulates the N pixels of one square tile, which
// arrive four per PIXEL write, and produces the rounded average.
// Register map: 0 CTRL, 1 STATUS, 2 PIXEL, 3 RESULT, 4 COUNT, 5 SUM.
module impix_avs_pixelizer #(
    parameter int PIX_W    = 8,
    parameter int LOG2_BLK = 2
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    impix_avs_pixelizer_if.slave        avs,
    output logic [3:0]                  indicators,
    output logic                        irq,
    output logic [1:0]                  dbg_state_o
);
    localparam int SHIFT = 2 * LOG2_BLK;
    localparam int SUM_W = PIX_W + SHIFT;
    localparam int CNT_W = SHIFT + 1;
    localparam logic [CNT_W-1:0] N_PIX = CNT_W'(1 << SHIFT);
    localparam logic [SUM_W:0]   HALF  = (SUM_W + 1)'(1 << (SHIFT - 1));

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIX_W-1:0]   result_q, result_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [3:0]         ind_q, ind_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rdv_q, rdv_d;

    logic               wait_w, wr_acc, rd_acc, busy_d;
    logic [SUM_W-1:0]   pix_add;
    logic [SUM_W:0]     rounded;
    logic [31:0]        rd_mux;

    // FINAL lasts one cycle; stalling only then keeps RESULT reads fresh.
    assign wait_w = (state_q == S_FINAL) && (avs.avs_read || avs.avs_write);
    assign wr_acc = avs.avs_write && !wait_w;
    assign rd_acc = avs.avs_read && !wait_w;

    // Sum of the four zero-extended pixels in the current write word.
    always_comb begin
        pix_add = '0;
        for (int k = 0; k < 4; k++) begin
            pix_add = pix_add + SUM_W'(avs.avs_writedata[k*8 +: PIX_W]);
        end
    end

    // Read mux sees only registered values, so a simultaneous write is
    // observed by the next read, not this one.
    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            3'd0:    rd_mux = {30'd0, irq_en_q, 1'b0};
            3'd1:    rd_mux = {29'd0, ovf_q, done_q, ind_q[0]};
            3'd3:    rd_mux = 32'(result_q);
            3'd4:    rd_mux = 32'(cnt_q);
            3'd5:    rd_mux = 32'(sum_q);
            default: rd_mux = '0;
        endcase
    end

    // Next-state logic for the FSM, datapath and status flags.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        rounded  = {1'b0, sum_q} + HALF;

        if (state_q == S_FINAL) begin
            result_d = rounded[SHIFT +: PIX_W];
            done_d   = 1'b1;
            state_d  = S_DONE;
        end

        if (wr_acc) begin
            case (avs.avs_address)
                3'd0: begin
                    irq_en_d = avs.avs_writedata[1];
                    if (avs.avs_writedata[0]) begin
                        sum_d   = '0;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = S_ACCUM;
                    end
                end
                3'd1: begin
                    if (avs.avs_writedata[1]) done_d = 1'b0;
                    if (avs.avs_writedata[2]) ovf_d  = 1'b0;
                end
                3'd2: begin
                    if (state_q == S_ACCUM) begin
                        sum_d = sum_q + pix_add;
                        cnt_d = cnt_q + CNT_W'(4);
                        if (cnt_d == N_PIX) state_d = S_FINAL;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        busy_d  = (state_d == S_ACCUM) || (state_d == S_FINAL);
        ind_d   = {done_d & irq_en_d, ovf_d, done_d, busy_d};
        rdv_d   = rd_acc;
        rdata_d = rd_acc ? rd_mux : 32'd0;
    end

    // State and registered outputs; reset drops everything including a read in flight.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ind_q    <= '0;
            rdata_q  <= '0;
            rdv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            ind_q    <= ind_d;
            rdata_q  <= rdata_d;
            rdv_q    <= rdv_d;
        end
    end

    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rdv_q;
    assign avs.avs_waitrequest   = wait_w;
    assign indicators            = ind_q;
    assign irq                   = ind_q[3];
    assign dbg_state_o           = state_q;
endmodule

// File: tb/tb_impix_avs_pixelizer.sv
// Bench for the tile pixelizer with LOG2_BLK=2 (16-pixel tiles).
module tb_impix_avs_pixelizer;
    logic       clk;
    logic       rst_n;
    logic [3:0] indicators;
    logic       irq;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] exp_q[$];
    int          acc_q[$];

    impix_avs_pixelizer_if bus ();

    impix_avs_pixelizer #(.PIX_W(8), .LOG2_BLK(2)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs           (bus.slave),
        .indicators    (indicators),
        .irq           (irq),
        .dbg_state_o   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // driver: one command, waits out waitrequest (bounded)
    task automatic bus_cmd(input logic rd, input logic wr, input logic [2:0] a,
                           input logic [31:0] wd, input logic [31:0] exp, output int stalls);
        stalls = 0;
        @(negedge clk);
        bus.avs_address   = a;
        bus.avs_read      = rd;
        bus.avs_write     = wr;
        bus.avs_writedata = wd;
        if (rd) exp_q.push_back(exp);
        #1;
        while (bus.avs_waitrequest && stalls < 4) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (bus.avs_waitrequest) begin
            checks++;
            errors++;
            $display("FAIL waitrequest_timeout: still high after %0d cycles, expected low", stalls);
        end
        @(posedge clk);
        #1;
        if (rd) acc_q.push_back(cyc);
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        int s;
        bus_cmd(1'b0, 1'b1, a, d, 32'd0, s);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        int s;
        bus_cmd(1'b1, 1'b0, a, 32'd0, exp, s);
    endtask

    task automatic rd_stall(input logic [2:0] a, input logic [31:0] exp, input int exp_stalls);
        int s;
        bus_cmd(1'b1, 1'b0, a, 32'd0, exp, s);
        chk("read_stall_cycles", 32'(s), 32'(exp_stalls));
    endtask

    task automatic chk_ind(input string name, input logic [3:0] exp_ind, input logic exp_irq);
        chk({name, "_indicators"}, 32'(indicators), 32'(exp_ind));
        chk({name, "_irq"}, 32'(irq), 32'(exp_irq));
    endtask

    // scoreboard monitor: pops on every read response
    always @(negedge clk) begin
        if (rst_n && bus.avs_readdatavalid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_readdatavalid: got data 0x%0h with no read pending", bus.avs_readdata);
            end else begin
                logic [31:0] e;
                int a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("readdata", bus.avs_readdata, e);
                chk("read_latency_cycle", 32'(cyc), 32'(a));
            end
        end
    end

    initial begin
        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        rst_n = 1'b0;
        idle(3);
        chk_ind("in_reset", 4'b0000, 1'b0);
        chk("in_reset_rdv", 32'(bus.avs_readdatavalid), 32'd0);
        rst_n = 1'b1;
        idle(2);
        chk_ind("after_reset", 4'b0000, 1'b0);
        chk("after_reset_waitrequest", 32'(bus.avs_waitrequest), 32'd0);
        rd(3'd0, 32'h0);

        // PIXEL write in IDLE is ignored and flags overflow
        wr(3'd2, 32'h01010101);
        rd(3'd1, 32'h4);
        rd(3'd5, 32'h0);
        idle(2);
        chk_ind("idle_overflow", 4'b0100, 1'b0);

        // uniform tile with interrupt enabled
        wr(3'd0, 32'h3);
        rd(3'd1, 32'h1);
        idle(2);
        chk_ind("accum", 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) wr(3'd2, 32'h10101010);
        idle(2);
        rd(3'd3, 32'h10);
        rd(3'd5, 32'h100);
        rd(3'd4, 32'd16);
        rd(3'd1, 32'h2);
        rd(3'd0, 32'h2);
        idle(2);
        chk_ind("uniform_done", 4'b1010, 1'b1);

        // rounding: pixels 0..15
        wr(3'd0, 32'h3);
        wr(3'd2, 32'h03020100);
        wr(3'd2, 32'h07060504);
        wr(3'd2, 32'h0B0A0908);
        wr(3'd2, 32'h0F0E0D0C);
        idle(2);
        rd(3'd5, 32'd120);
        rd(3'd3, 32'd8);

        // full-scale tile
        wr(3'd0, 32'h3);
        for (int i = 0; i < 4; i++) wr(3'd2, 32'hFFFFFFFF);
        idle(2);
        rd(3'd5, 32'd4080);
        rd(3'd3, 32'hFF);

        // overflow in DONE, then write-1-to-clear
        wr(3'd2, 32'hFFFFFFFF);
        rd(3'd1, 32'h6);
        rd(3'd5, 32'd4080);
        idle(2);
        chk_ind("done_overflow", 4'b1110, 1'b1);
        wr(3'd1, 32'h6);
        rd(3'd1, 32'h0);
        idle(2);
        chk_ind("status_cleared", 4'b0000, 1'b0);

        // restart mid-tile
        wr(3'd0, 32'h1);
        rd(3'd0, 32'h0);
        wr(3'd2, 32'h11111111);
        wr(3'd2, 32'h11111111);
        rd(3'd4, 32'd8);
        wr(3'd0, 32'h3);
        rd(3'd4, 32'd0);
        rd(3'd1, 32'h1);
        idle(2);
        chk_ind("restart", 4'b0001, 1'b0);

        // back-to-back: read RESULT right after the last PIXEL write
        for (int i = 0; i < 4; i++) wr(3'd2, 32'h20202020);
        rd_stall(3'd3, 32'h20, 1);
        rd(3'd4, 32'd16);
        idle(2);
        chk_ind("restart_done", 4'b1010, 1'b1);

        // same-cycle read+write of STATUS returns the pre-write value
        begin
            int s;
            bus_cmd(1'b1, 1'b1, 3'd1, 32'h2, 32'h2, s);
        end
        rd(3'd1, 32'h0);
        idle(2);
        chk_ind("rw_clear", 4'b0000, 1'b0);

        // unused addresses
        rd(3'd6, 32'h0);
        wr(3'd7, 32'hFFFFFFFF);
        rd(3'd7, 32'h0);
        rd(3'd3, 32'h20);

        // drain scoreboard (bounded)
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
